// File: rtl/dualmem_req_adapter_if.sv
// Request / RAM-port / response bundle for dualmem_req_adapter.
// The adapter sits on the slave modport; the requester, the RAM and the response consumer sit on the master side.
interface dualmem_req_adapter_if #(
  parameter int ADDR_WIDTH = 9
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic                  req_we_i;
  logic [7:0]            req_be_i;
  logic [63:0]           req_wdata_i;

  logic                  mem_en_o;
  logic [7:0]            mem_we_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [63:0]           mem_wdata_o;
  logic [63:0]           mem_rdata_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic                  rsp_we_o;
  logic [63:0]           rsp_rdata_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
    input  mem_rdata_i, rsp_ready_i,
    output req_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output rsp_valid_o, rsp_we_o, rsp_rdata_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_we_i, req_be_i, req_wdata_i,
    output mem_rdata_i, rsp_ready_i,
    input  req_ready_o, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  rsp_valid_o, rsp_we_o, rsp_rdata_o
  );
endinterface

// File: rtl/dualmem_req_adapter.sv
// Turns a valid/ready request stream into single-cycle accesses on a 64-bit RAM port
// and returns one in-order response per request through a small circular FIFO.
module dualmem_req_adapter #(
  parameter int ADDR_WIDTH = 9,
  parameter int RSP_DEPTH  = 3
) (
  input logic                    clk_i,
  input logic                    rst_i,
  dualmem_req_adapter_if.slave   bus
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  logic             inflight;
  logic             inflight_we;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_we   [RSP_DEPTH];
  logic [63:0]      fifo_data [RSP_DEPTH];

  logic req_ready;
  logic accept;
  logic push;
  logic pop;
  logic rsp_valid;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Slots already promised = queued responses plus the one read still on the RAM port;
  // only registered state feeds this, so no path exists from req_valid_i or rsp_ready_i.
  assign req_ready = !rst_i &&
                     (({1'b0, count} + {{CNT_W{1'b0}}, inflight}) < (CNT_W + 1)'(RSP_DEPTH));
  assign accept    = bus.req_valid_i && req_ready;
  assign rsp_valid = (count != '0);
  assign push      = inflight;
  assign pop       = rsp_valid && bus.rsp_ready_i;

  assign bus.req_ready_o = req_ready;
  assign bus.mem_en_o    = accept;
  assign bus.mem_we_o    = (accept && bus.req_we_i) ? bus.req_be_i : 8'h00;
  assign bus.mem_addr_o  = ADDR_WIDTH'(bus.req_addr_i);
  assign bus.mem_wdata_o = bus.req_wdata_i;

  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_we_o    = rsp_valid ? fifo_we[rd_ptr]   : 1'b0;
  assign bus.rsp_rdata_o = rsp_valid ? fifo_data[rd_ptr] : 64'h0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight    <= 1'b0;
      inflight_we <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      inflight    <= accept;
      inflight_we <= accept && bus.req_we_i;
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: count gates every read of it.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_we[wr_ptr]   <= inflight_we;
      fifo_data[wr_ptr] <= inflight_we ? 64'h0 : bus.mem_rdata_i;
    end
  end

  assert property (@(posedge clk_i) disable iff (rst_i)
                   !(push && (count == CNT_W'(RSP_DEPTH))));

endmodule

// File: tb/tb_dualmem_req_adapter.sv
// Randomized bench for dualmem_req_adapter: a behavioural RAM on the port side and a
// reference model (byte-addressable memory image + ordered expected-response queue).
module tb_dualmem_req_adapter;

  localparam int AW = 9;
  localparam int D  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dualmem_req_adapter_if #(.ADDR_WIDTH(AW)) bus ();

  dualmem_req_adapter #(.ADDR_WIDTH(AW), .RSP_DEPTH(D)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Attached RAM: synchronous read, per-byte write enables.
  logic [63:0] ram [512];
  logic [63:0] ram_q;
  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      for (int b = 0; b < 8; b++)
        if (bus.mem_we_o[b]) ram[bus.mem_addr_o][b*8 +: 8] <= bus.mem_wdata_o[b*8 +: 8];
      ram_q <= ram[bus.mem_addr_o];
    end
  end
  assign bus.mem_rdata_i = ram_q;

  typedef struct {
    logic        we;
    logic [63:0] data;
    int          t;
  } rsp_t;

  logic [63:0] ref_mem [512];
  rsp_t        expq [$];
  int          outstanding = 0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] last_rdata;
  logic        last_we;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: drive at the falling edge, check combinational outputs just after,
  // and advance the model by whatever the rising edge will commit.
  task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [7:0] be, input logic [63:0] wd, input logic rr,
                      output logic acc);
    logic exp_ready;
    logic exp_rv;
    rsp_t r;
    @(negedge clk);
    bus.req_valid_i = v;
    bus.req_we_i    = we;
    bus.req_addr_i  = a;
    bus.req_be_i    = be;
    bus.req_wdata_i = wd;
    bus.rsp_ready_i = rr;
    #1;
    exp_ready = (outstanding < D);
    exp_rv    = (expq.size() > 0) && (expq[0].t + 2 <= cyc);
    chk("req_ready", bus.req_ready_o, exp_ready);
    chk("rsp_valid", bus.rsp_valid_o, exp_rv);
    acc = v && exp_ready;
    chk("mem_en", bus.mem_en_o, acc);
    if (!bus.rsp_valid_o) begin
      chk("idle_rsp_we", bus.rsp_we_o, 0);
      chk("idle_rsp_rdata", bus.rsp_rdata_o, 0);
    end
    if (!acc) chk("idle_mem_we", bus.mem_we_o, 0);
    if (exp_rv && rr) begin
      r = expq.pop_front();
      chk("rsp_we", bus.rsp_we_o, r.we);
      chk("rsp_rdata", bus.rsp_rdata_o, r.data);
      last_we    = r.we;
      last_rdata = r.data;
      outstanding--;
    end
    if (acc) begin
      chk("mem_addr", bus.mem_addr_o, a);
      chk("mem_we", bus.mem_we_o, we ? be : 8'h00);
      if (we) begin
        chk("mem_wdata", bus.mem_wdata_o, wd);
        for (int b = 0; b < 8; b++)
          if (be[b]) ref_mem[a][b*8 +: 8] = wd[b*8 +: 8];
        r.we = 1'b1; r.data = 64'h0;
      end else begin
        r.we = 1'b0; r.data = ref_mem[a];
      end
      r.t = cyc;
      expq.push_back(r);
      outstanding++;
    end
    cyc++;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [7:0] be,
                       input logic [63:0] wd, input logic rr);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      step(1'b1, we, a, be, wd, rr, acc);
      n++;
    end
    chk("issue_accepted", acc, 1'b1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while (expq.size() > 0 && n < 50) begin
      step(1'b0, 1'b0, '0, 8'h00, 64'h0, 1'b1, acc);
      n++;
    end
    chk("drain_empty", expq.size(), 0);
  endtask

  task automatic apply_reset(input int hold);
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid_i = 1'b1;
    #1;
    chk("rst_rsp_valid", bus.rsp_valid_o, 0);
    chk("rst_rsp_we", bus.rsp_we_o, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata_o, 0);
    chk("rst_mem_en", bus.mem_en_o, 0);
    chk("rst_mem_we", bus.mem_we_o, 0);
    chk("rst_req_ready", bus.req_ready_o, 0);
    expq.delete();
    outstanding = 0;
    repeat (hold) @(negedge clk);
    bus.req_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst_release_ready", bus.req_ready_o, 1);
  endtask

  initial begin
    logic        acc;
    int          cnt;
    int          idx;
    int          budget;
    logic        h_we;
    logic [AW-1:0] h_a;
    logic [7:0]  h_be;
    logic [63:0] h_wd;
    logic        have;
    logic        v;
    logic        rr;

    bus.req_valid_i = 1'b0;
    bus.req_we_i    = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_be_i    = 8'h00;
    bus.req_wdata_i = 64'h0;
    bus.rsp_ready_i = 1'b0;
    for (int i = 0; i < 512; i++) ref_mem[i] = 64'h0;

    apply_reset(3);

    // Write then read back, full byte enables.
    issue(1'b1, 9'd5, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b1);
    issue(1'b0, 9'd5, 8'h00, 64'h0, 1'b1);
    drain();
    chk("r21_rdata", last_rdata, 64'h0123_4567_89AB_CDEF);
    chk("r21_we", last_we, 0);

    // Partial byte-enable overwrite, then a zero-enable write that must not disturb data.
    issue(1'b1, 9'd7, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue(1'b1, 9'd7, 8'h0F, 64'h0, 1'b1);
    issue(1'b1, 9'd7, 8'h00, 64'h1234_5678_1234_5678, 1'b1);
    drain();
    chk("zero_be_rsp_we", last_we, 1);
    issue(1'b0, 9'd7, 8'h00, 64'h0, 1'b1);
    drain();
    chk("r22_rdata", last_rdata, 64'hFFFF_FFFF_0000_0000);

    // Fill the whole RAM with random data so every later read is defined.
    for (int i = 0; i < 512; i++)
      issue(1'b1, AW'(i), 8'hFF, {$urandom, $urandom}, 1'b1);
    drain();

    // Backpressure: only D reads fit while nothing is consumed.
    cnt = 0;
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, AW'(idx), 8'h00, 64'h0, 1'b0, acc);
      if (acc) begin cnt++; idx++; end
    end
    chk("bp_accepts", cnt, D);
    chk("bp_ready_low", bus.req_ready_o, 0);
    budget = 0;
    while (idx < 10 && budget < 60) begin
      step(1'b1, 1'b0, AW'(idx), 8'h00, 64'h0, 1'b1, acc);
      if (acc) idx++;
      budget++;
    end
    chk("bp_all_issued", idx, 10);
    drain();

    // Full-rate burst over the whole address space.
    cnt = 0;
    for (int i = 0; i < 512; i++) begin
      step(1'b1, 1'b0, AW'(i), 8'h00, 64'h0, 1'b1, acc);
      if (acc) cnt++;
    end
    chk("burst_accepts", cnt, 512);
    step(1'b1, 1'b0, AW'(0), 8'h00, 64'h0, 1'b1, acc);
    chk("burst_wrap_accept", acc, 1);
    drain();

    // Reset with two responses queued and one read on the RAM port.
    for (int i = 0; i < 3; i++) issue(1'b0, AW'(20 + i), 8'h00, 64'h0, 1'b0);
    apply_reset(2);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 8'h00, 64'h0, 1'b1, acc);

    // Randomly throttled mixed traffic.
    cnt    = 0;
    budget = 0;
    have   = 1'b0;
    h_we = 1'b0; h_a = '0; h_be = 8'h00; h_wd = 64'h0;
    while (cnt < 10000 && budget < 80000) begin
      if (!have) begin
        h_we = 1'($urandom_range(0, 1));
        h_a  = AW'($urandom_range(0, 511));
        h_be = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        h_wd = {$urandom, $urandom};
        have = 1'b1;
      end
      v  = ($urandom_range(0, 3) != 0);
      rr = (((cyc / 200) % 2) == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) != 0);
      step(v, h_we, h_a, h_be, h_wd, rr, acc);
      if (acc) begin cnt++; have = 1'b0; end
      budget++;
    end
    chk("rand_accepts", cnt, 10000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dualmem_req_adapter.md
DUALMEM_REQ_ADAPTER -- requirements
Module: dualmem_req_adapter

Interface
REQ-001: Parameters SHALL be:
- ADDR_WIDTH, default 9, word address width of the attached 64-bit dual-port RAM port.
- RSP_DEPTH, default 3, response FIFO entries; legal range 2..8.

REQ-002: Ports SHALL be (name, direction, width, meaning):
- clk_i  in  1  single clock; the RAM port clock is driven from this clock.
- rst_i  in  1  reset, asynchronous, active-high.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_addr_i  in  ADDR_WIDTH  64-bit word address.
- req_we_i  in  1  1 = write, 0 = read.
- req_be_i  in  8  byte enables for writes.
- req_wdata_i  in  64  write data.
- mem_en_o  out  1  RAM port enable.
- mem_we_o  out  8  RAM per-byte write enables.
- mem_addr_o  out  ADDR_WIDTH  RAM address.
- mem_wdata_o  out  64  RAM write data.
- mem_rdata_i  in  64  RAM read data, valid exactly 1 cycle after mem_en_o.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when high together with rsp_valid_o.
- rsp_we_o  out  1  response belongs to a write.
- rsp_rdata_o  out  64  read data; 0 for write responses.

Function
REQ-003: Acceptance SHALL occur in any cycle where req_valid_i && req_ready_o.

REQ-004: In an accept cycle, the RAM port SHALL be driven combinationally in the same cycle:
- mem_en_o=1, mem_addr_o=req_addr_i, mem_wdata_o=req_wdata_i.
- mem_we_o = req_we_i ? req_be_i : 8'h00.

REQ-005: In non-accept cycles, mem_en_o and mem_we_o SHALL be 0; mem_addr_o and mem_wdata_o are don't-care.

REQ-006: An inflight register SHALL be set on the rising edge ending an accept cycle, cleared otherwise, and record the request's we bit.

REQ-007: In a cycle with inflight=1, the block SHALL push into the response FIFO on the next edge:
- {we=recorded we, data = we ? 0 : mem_rdata_i}.

REQ-008: The response FIFO SHALL be a circular buffer:
- RSP_DEPTH entries; pointers wrap modulo RSP_DEPTH.
- count register of width clog2(RSP_DEPTH+1).

REQ-009: rsp_valid_o SHALL be (count!=0); rsp_we_o and rsp_rdata_o SHALL show the head entry, and be 0 when count==0.

REQ-010: A pop SHALL occur when rsp_valid_o && rsp_ready_i; simultaneous push and pop SHALL leave count unchanged and advance both pointers.

REQ-011: req_ready_o SHALL be (count + inflight) < RSP_DEPTH, computed from registered state only, with no combinational path from rsp_ready_i or req_valid_i.

REQ-012: By REQ-011 the FIFO SHALL never overflow; a push when count==RSP_DEPTH is a design error flagged by an assertion.

REQ-013: Responses SHALL be returned in request order; reads and writes share one ordered stream.

REQ-014: A write with req_be_i==0 SHALL still be accepted, leave RAM contents unmodified, and produce one write response.

REQ-015: Latency SHALL be fixed: request accept in cycle N gives rsp_valid_o=1 in cycle N+2 at the earliest, when the FIFO is empty at push time.

REQ-016: With RSP_DEPTH>=3 and rsp_ready_i held 1, the block SHALL sustain one accept per cycle indefinitely.

REQ-017: Under rsp_ready_i=0, at most RSP_DEPTH requests SHALL be accepted before req_ready_o drops; it rises again the cycle after the first pop.

Reset
REQ-018: While rst_i=1, and immediately on its assertion, the block SHALL clear state and hold outputs:
- count=0, both pointers=0, inflight=0.
- rsp_valid_o=0, rsp_we_o=0, rsp_rdata_o=0, mem_en_o=0, mem_we_o=0, req_ready_o=0.

REQ-019: On the first cycle after rst_i deasserts, req_ready_o SHALL be 1.

REQ-020: Reset asserted mid-operation SHALL discard the inflight request and all queued responses; no response for them SHALL ever appear.

Verification
REQ-021: Write addr 5, data 64'h0123_4567_89AB_CDEF, be FF, then read addr 5 with rsp_ready_i=1 -> write response {we=1, rdata=0} at accept+2; read response rdata=64'h0123_4567_89AB_CDEF at read accept+2.

REQ-022: Write addr 7 with data all-ones, then write addr 7 with data 0 and be 8'h0F, then read addr 7 -> rdata=64'hFFFF_FFFF_0000_0000.

REQ-023: rsp_ready_i=0, req_valid_i held 1 with reads to addrs 0..9 -> exactly RSP_DEPTH (3) accepts, then req_ready_o=0. Raise rsp_ready_i -> remaining reads complete in order, addrs 0..9.

REQ-024: Back-to-back reads of addrs 0..511 with rsp_ready_i=1 -> 512 accepts in 512 consecutive cycles; addr wraps to 0 cleanly; responses are in order with no gaps after the initial 2-cycle latency.

REQ-025: Assert rst_i one cycle after accepting a read while 2 responses are queued -> rsp_valid_o=0 immediately; no stale response after reset release; req_ready_o=1 on the first post-reset cycle.

REQ-026: Random valid/ready throttling over 10k requests against a 512x64 reference memory model -> all responses match the model in order, and the FIFO never overflows.
